// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-address width, MIPS opcode/funct
// constants used by the ID-stage decode, and the hazard controller state type.
package pipe_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIVU    = 6'h1b;

  typedef enum logic {
    IDLE     = 1'b0,
    MDU_BUSY = 1'b1
  } hz_state_e;

endpackage

// File: rtl/mdu_occupancy_cnt.sv
// Down-counter tracking how many EX cycles remain for an in-flight MULTU/DIVU.
// Loads on issue, decrements while busy, saturates at zero and flags zero.
module mdu_occupancy_cnt #(
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned LOAD_VAL = 31
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement without wrapping below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(LOAD_VAL);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard/stall controller: load-use stall, multi-cycle MDU
// occupancy stall, and IF/ID flush on taken branches. Outputs are
// combinational from state and inputs so a stall takes effect the same cycle.
// Build option: FORWARDING_EN -- when undefined, also stall on any RAW
// dependence against the EX and MEM writers (datapath without forwarding).
module hazard_stall_ctrl #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MDU_CYCLES = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic              ID_UsesRt,
  input  logic              EX_MemRead,
  input  logic              EX_RegWrite,
  input  logic [REG_AW-1:0] EX_Rd,
  input  logic              MEM_RegWrite,
  input  logic [REG_AW-1:0] MEM_Rd,
  input  logic              ID_MduStart,
  input  logic              ID_MduRead,
  input  logic              EX_Taken,
  output logic              PC_Write,
  output logic              IFID_Write,
  output logic              IFID_Flush,
  output logic              IDEX_Bubble,
  output logic              Mdu_Busy
);

  import pipe_pkg::*;

  localparam int unsigned CNT_W = (MDU_CYCLES > 1) ? $clog2(MDU_CYCLES) : 1;

  hz_state_e state_q;
  logic      mdu_zero;
  logic      start_accept;
  logic      lu_haz;
  logic      mdu_haz;
  logic      raw_haz;
  logic      stall;

  // Hazard detection; register 0 is never a dependence.
  always_comb begin
    lu_haz  = EX_MemRead && (EX_Rd != '0) &&
              ((EX_Rd == ID_Rs) || (ID_UsesRt && (EX_Rd == ID_Rt)));
    mdu_haz = (state_q == MDU_BUSY) && (ID_MduStart || ID_MduRead);
`ifdef FORWARDING_EN
    raw_haz = 1'b0;
`else
    raw_haz = (EX_RegWrite && (EX_Rd != '0) &&
               ((EX_Rd == ID_Rs) || (ID_UsesRt && (EX_Rd == ID_Rt)))) ||
              (MEM_RegWrite && (MEM_Rd != '0) &&
               ((MEM_Rd == ID_Rs) || (ID_UsesRt && (MEM_Rd == ID_Rt))));
`endif
    stall   = lu_haz || mdu_haz || raw_haz;
  end

`ifdef FORWARDING_EN
  logic unused_fwd;
  assign unused_fwd = ^{EX_RegWrite, MEM_RegWrite, MEM_Rd};
`endif

  // Pipeline controls: reset holds everything, redirect beats any stall.
  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    if (!Rst_n) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (EX_Taken) begin
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (stall) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end
  end

  assign start_accept = (state_q == IDLE) && ID_MduStart && PC_Write && !EX_Taken;
  assign Mdu_Busy     = Rst_n && (state_q == MDU_BUSY);

  // MDU occupancy state: enter on an accepted MULTU/DIVU, leave when count hits 0.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:     if (start_accept) state_q <= MDU_BUSY;
        MDU_BUSY: if (mdu_zero)     state_q <= IDLE;
        default:                    state_q <= IDLE;
      endcase
    end
  end

  mdu_occupancy_cnt #(
    .CNT_W    (CNT_W),
    .LOAD_VAL (MDU_CYCLES - 1)
  ) u_mdu_cnt (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .load_i (start_accept),
    .dec_i  (state_q == MDU_BUSY),
    .zero_o (mdu_zero)
  );

endmodule
